weight_fetch_arbiter: RTL

- Shares one synchronous weight-memory read port between the five convolution layers' weight-read requesters.
- Each requester keeps its own address counter. The counter starts at that layer's base address and wraps at the layer's weight count.
- The block returns one weight per grant, with a one-hot response valid that identifies the owning layer.
- It sits between the conv-layer weight-read strobes and a single merged weight ROM/SRAM holding all conv weights back to back.

---
 rtl/weight_fetch_arbiter_if.sv | 27 ++
 rtl/weight_fetch_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/weight_fetch_arbiter_if.sv
// Weight-fetch bus: conv-layer read requests, merged weight-memory port and per-layer responses.
// The arbiter uses the slave view; requesters plus memory use the master view.
interface weight_fetch_arbiter_if #(
    parameter int NUM_REQ      = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 19
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      restart;
    logic [NUM_REQ-1:0]      gnt;
    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WEIGHT_WIDTH-1:0] mem_rd_data;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [WEIGHT_WIDTH-1:0] rsp_data;
    logic [NUM_REQ-1:0]      layer_done;

    modport master (
        output req, restart, mem_rd_data,
        input  gnt, mem_rd_en, mem_addr, rsp_valid, rsp_data, layer_done
    );

    modport slave (
        input  req, restart, mem_rd_data,
        output gnt, mem_rd_en, mem_addr, rsp_valid, rsp_data, layer_done
    );
endinterface

// File: rtl/weight_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous weight-memory read port between the conv layers.
// Each layer owns a wrapping address counter; responses return two cycles after the request is sampled.
module weight_fetch_arbiter #(
    parameter int NUM_REQ      = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 19,
    parameter logic [NUM_REQ*ADDR_WIDTH-1:0] BASE_ADDRS =
        {19'd276256, 19'd128800, 19'd55072, 19'd3872, 19'd0},
    parameter logic [NUM_REQ*ADDR_WIDTH-1:0] SIZES =
        {19'd73728, 19'd147456, 19'd73728, 19'd51200, 19'd3872}
) (
    input logic clk1,
    input logic rst,
    weight_fetch_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [NUM_REQ-1:0]    eligible;
    logic [ADDR_WIDTH-1:0] cnt [NUM_REQ];
    ptr_t                  ptr;
    ptr_t                  win;
    ptr_t                  cand;
    logic                  found;
    logic [ADDR_WIDTH-1:0] win_cnt;
    logic [ADDR_WIDTH-1:0] win_base;
    logic [ADDR_WIDTH-1:0] win_size;
    logic                  win_last;

    logic [NUM_REQ-1:0]    gnt_q;
    logic                  mem_rd_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  last_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [NUM_REQ-1:0]    layer_done_q;

    function automatic logic [ADDR_WIDTH-1:0] field(input logic [NUM_REQ*ADDR_WIDTH-1:0] vec,
                                                    input int idx);
        return vec[idx*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    // A requester being restarted this cycle sits out arbitration, so its counter never sees both events.
    assign eligible = bus.req & ~bus.restart;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr_t'((int'(ptr) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_cnt  = cnt[win];
    assign win_base = field(BASE_ADDRS, int'(win));
    assign win_size = field(SIZES, int'(win));
    assign win_last = (win_cnt == win_size - ADDR_WIDTH'(1));

    // gnt doubles as the first tag stage; rsp_valid is the second, so a reset flushes in-flight reads.
    always_ff @(posedge clk1) begin
        if (rst) begin
            gnt_q        <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            last_q       <= 1'b0;
            rsp_valid_q  <= '0;
            layer_done_q <= '0;
            ptr          <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            gnt_q       <= '0;
            mem_rd_en_q <= found;
            last_q      <= found && win_last;
            if (found) begin
                gnt_q[win] <= 1'b1;
                mem_addr_q <= win_base + win_cnt;
                ptr        <= (win == ptr_t'(NUM_REQ - 1)) ? '0 : win + ptr_t'(1);
            end
            rsp_valid_q  <= gnt_q;
            layer_done_q <= last_q ? gnt_q : '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.restart[i]) begin
                    cnt[i] <= '0;
                end else if (found && win == ptr_t'(i)) begin
                    cnt[i] <= win_last ? '0 : cnt[i] + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.layer_done = layer_done_q;
    assign bus.rsp_data   = (|rsp_valid_q) ? bus.mem_rd_data : '0;
endmodule
